// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM sequencer.
// This file holds the state codes, the datapath select encodings and the ALU command decode.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // Map a data-processing cmd field to an ALU operation.
    // Commands the ALU does not implement fall back to ADD.
    function automatic logic [2:0] decodeAluCtrl(input logic [3:0] cmd);
        logic [2:0] ctrl;
        case (cmd)
            CMD_ADD: ctrl = ALU_ADD;
            CMD_SUB: ctrl = ALU_SUB;
            CMD_CMP: ctrl = ALU_SUB;
            CMD_AND: ctrl = ALU_AND;
            CMD_ORR: ctrl = ALU_ORR;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/arm_condcheck.sv
// ARM condition-code evaluation against the stored NZCV flags.
// Code 1111 is reserved in this core and always fails.
module arm_condcheck (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic flagN;
    logic flagZ;
    logic flagC;
    logic flagV;

    assign {flagN, flagZ, flagC, flagV} = Flags;

    // Evaluate the condition field from EQ through AL
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = flagZ;
            4'b0001: CondEx = ~flagZ;
            4'b0010: CondEx = flagC;
            4'b0011: CondEx = ~flagC;
            4'b0100: CondEx = flagN;
            4'b0101: CondEx = ~flagN;
            4'b0110: CondEx = flagV;
            4'b0111: CondEx = ~flagV;
            4'b1000: CondEx = flagC & ~flagZ;
            4'b1001: CondEx = ~flagC | flagZ;
            4'b1010: CondEx = (flagN == flagV);
            4'b1011: CondEx = (flagN != flagV);
            4'b1100: CondEx = ~flagZ & (flagN == flagV);
            4'b1101: CondEx = flagZ | (flagN != flagV);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle sequencer for the ARM core with a single variable-latency memory port.
// Walks each instruction through fetch/decode/execute/memory/writeback and owns the NZCV flags.
module arm_mc_ctrl
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [3:0] cmd;
    logic [2:0] aluDec;
    logic       condEx;
    logic       inExec;
    logic       aluWbWrite;

    assign cmd        = Funct[4:1];
    assign aluDec     = decodeAluCtrl(cmd);
    assign inExec     = (state_q == S_EXECR) || (state_q == S_EXECI);
    assign aluWbWrite = (cmd != CMD_CMP);

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign State  = state_q;

    arm_condcheck u_condcheck (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (condEx)
    );

    // State and flags registers; reset drops straight back to FETCH with clear flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Flags capture on the edge leaving EXEC; logical ops keep the previous carry and overflow
    always_comb begin
        flags_d = flags_q;
        if (inExec && (Funct[0] || (cmd == CMD_CMP))) begin
            flags_d[3:2] = ALUFlags[3:2];
            if ((aluDec == ALU_ADD) || (aluDec == ALU_SUB)) begin
                flags_d[1:0] = ALUFlags[1:0];
            end
        end
    end

    // Next-state selection and Moore datapath controls; IRWrite/PCWrite in FETCH follow MemReady
    always_comb begin
        state_d    = state_q;
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (!condEx) begin
                    state_d = S_FETCH;
                end else begin
                    case (Op)
                        2'b01:   state_d = S_MEMADR;
                        2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcB    = SRCB_RD2;
                ALUControl = aluDec;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = aluDec;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = aluWbWrite;
                PCWrite   = aluWbWrite && (Rd == 4'd15);
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALURESULT;
                PCWrite    = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule
